// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: size encodings, FSM states and request legality shared by the data-memory controller.
package dmem_ctrl_pkg;
  typedef enum logic [2:0] {SZ_W = 3'b000, SZ_H = 3'b001, SZ_B = 3'b010, SZ_HU = 3'b011, SZ_BU = 3'b100} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int LANES = 4;
  function automatic logic illegal_req(input logic rd, input logic wr, input logic [2:0] sel, input logic [1:0] off);
    return (rd && wr) || (rd && sel > 3'b100) || (wr && sel > 3'b010) ||
           (sel == SZ_W && off != 2'b00) || ((sel == SZ_H || sel == SZ_HU) && off[0]);
  endfunction
endpackage

// File: rtl/dmem_ctrl_lane.sv
// dmem_lane: store lane replication/strobes and load right-align/zero-mask keyed by size and byte offset.
module dmem_lane
  import dmem_ctrl_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]       sel,
  input  logic [1:0]       off,
  input  logic [n-1:0]     wdata,
  input  logic [n-1:0]     rdata,
  output logic [n-1:0]     lane_wdata,
  output logic [n-1:0]     lane_rdata,
  output logic [LANES-1:0] lane_wstrb
);
  logic [n-1:0] shifted;
  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    lane_rdata = (sel == SZ_B || sel == SZ_BU) ? (shifted & n'(8'hFF)) :
                 (sel == SZ_H || sel == SZ_HU) ? (shifted & n'(16'hFFFF)) : shifted;
    lane_wdata = sel == SZ_B ? {(n/8){wdata[7:0]}} : sel == SZ_H ? {(n/16){wdata[15:0]}} : wdata;
    lane_wstrb = sel == SZ_B ? 4'b0001 << off : sel == SZ_H ? 4'b0011 << off : 4'b1111;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage load/store controller running a req/ready handshake with timeout and fault reporting.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int n       = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Memsel,
  input  logic [n-1:0]     Addr,
  input  logic [n-1:0]     DataW,
  output logic [n-1:0]     DataR,
  output logic             Stall,
  output logic             Fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [n-1:0]     mem_addr,
  output logic [n-1:0]     mem_wdata,
  output logic [LANES-1:0] mem_wstrb,
  input  logic [n-1:0]     mem_rdata,
  input  logic             mem_ready
);
  state_e state, state_nx;
  logic [TW-1:0] cnt;
  logic [n-1:0] lane_wdata, lane_rdata;
  logic [LANES-1:0] lane_wstrb;
  logic req, bad, last;
  assign req  = MemRead | MemWrite;
  assign bad  = illegal_req(MemRead, MemWrite, Memsel, Addr[1:0]);
  assign last = cnt == TW'(TIMEOUT - 1);
  dmem_lane #(.n(n)) u_lane (
    .sel(Memsel), .off(Addr[1:0]), .wdata(DataW), .rdata(mem_rdata),
    .lane_wdata(lane_wdata), .lane_rdata(lane_rdata), .lane_wstrb(lane_wstrb)
  );
  always_comb begin
    state_nx = state == IDLE ? (req ? (bad ? RESP : WAIT) : IDLE) :
               state == WAIT ? ((mem_ready || last) ? RESP : WAIT) : IDLE;
    Stall    = state == WAIT || (state == IDLE && req);
  end
  // Request inputs are held stable while stalled, so the live Memsel/Addr still describe the load on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      Fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      DataR     <= '0;
    end else begin
      state <= state_nx;
      Fault <= 1'b0;
      if (state == IDLE && req) begin
        Fault <= bad;
        if (!bad) begin
          mem_req   <= 1'b1;
          mem_we    <= MemWrite;
          mem_addr  <= {Addr[n-1:2], 2'b00};
          mem_wdata <= lane_wdata;
          mem_wstrb <= lane_wstrb;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (mem_ready || last) mem_req <= 1'b0;
        if (mem_ready && !mem_we) DataR <= lane_rdata;
        if (!mem_ready && last) Fault <= 1'b1;
      end
      if (state == RESP) cnt <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized accesses checked against a byte-level reference model.
module tb_dmem_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic MemRead = 1'b0, MemWrite = 1'b0, mem_ready = 1'b0;
  logic [2:0] Memsel = 3'b000;
  logic [31:0] Addr = '0, DataW = '0, mem_rdata = '0;
  logic [31:0] DataR, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic Stall, Fault, mem_req, mem_we;
  int checks = 0, failures = 0;
  logic [31:0] model_datar = '0;

  dmem_ctrl #(.n(32), .TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Memsel(Memsel),
    .Addr(Addr), .DataW(DataW), .DataR(DataR), .Stall(Stall), .Fault(Fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sel, input bit st);
    case (sel)
      3'd0: return 4;
      3'd1: return 2;
      3'd2: return 1;
      3'd3: return st ? 0 : 2;
      3'd4: return st ? 0 : 1;
      default: return 0;
    endcase
  endfunction

  // One access from IDLE; k = WAIT cycle carrying mem_ready (beyond TO means it never comes in time).
  task automatic access(input bit rd, input bit wr, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] dw, input logic [31:0] rdata, input int k);
    int nb, o, stalls, exp_stall;
    bit legal, tout, done, seen_req;
    logic [31:0] exp_r, exp_w;
    logic [3:0] exp_s;
    nb = nbytes(sel, wr);
    o = int'(addr[1:0]);
    legal = !(rd && wr) && nb != 0 && (o % nb) == 0;
    tout = legal && k > TO;
    exp_stall = !legal ? 1 : tout ? TO + 1 : k + 1;
    exp_r = '0; exp_w = '0; exp_s = '0;
    if (legal) begin
      for (int i = 0; i < nb; i++) begin
        exp_r[8*i +: 8] = rdata[8*(o+i) +: 8];
        exp_s[o+i] = 1'b1;
      end
      for (int j = 0; j < 4; j++) exp_w[8*j +: 8] = dw[8*(j % nb) +: 8];
    end
    MemRead = rd; MemWrite = wr; Memsel = sel; Addr = addr; DataW = dw; mem_rdata = rdata;
    stalls = 0; done = 0; seen_req = 0;
    for (int c = 1; c <= 40; c++) begin
      mem_ready = (c - 1 == k);
      @(negedge clk);
      if (mem_req) seen_req = 1;
      if (!Stall) begin
        done = 1;
        break;
      end
      if (legal && c >= 2) chk("wait_req", mem_req, 1);
      if (legal && c == 2) begin
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_we", mem_we, wr);
        if (wr) begin
          chk("mem_wdata", mem_wdata, exp_w);
          chk("mem_wstrb", mem_wstrb, exp_s);
        end
      end
      stalls++;
      @(posedge clk); #1;
    end
    if (legal && rd && !tout) model_datar = exp_r;
    chk("resp_reached", done, 1);
    chk("stall_cycles", stalls, exp_stall);
    chk("resp_fault", Fault, !legal || tout);
    chk("resp_datar", DataR, model_datar);
    chk("resp_req", mem_req, 0);
    if (!legal) chk("no_bus_cycle", seen_req, 0);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; mem_ready = 0;
    @(negedge clk);
    chk("idle_stall", Stall, 0);
    chk("idle_fault", Fault, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_datar", DataR, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h1003, 32'h0, 32'h80AA5511, 2);
    chk("lb_value", DataR, 32'h0000_0080);
    access(1, 0, 3'b011, 32'h2002, 32'h0, 32'hBEEF1234, 1);
    chk("lhu_value", DataR, 32'h0000_BEEF);
    access(0, 1, 3'b010, 32'h3001, 32'h0000_00A5, 32'h0, 1);
    access(0, 1, 3'b001, 32'h3002, 32'h0000_1234, 32'h0, 3);
    access(1, 0, 3'b000, 32'h4002, 32'h0, 32'hDEAD_BEEF, 1);
    access(1, 1, 3'b000, 32'h4000, 32'h0, 32'hDEAD_BEEF, 1);
    access(1, 0, 3'b000, 32'h4004, 32'h0, 32'h1111_2222, 1000);
    access(1, 0, 3'b000, 32'h4008, 32'h0, 32'h3333_4444, TO);
    access(1, 0, 3'b100, 32'h400A, 32'h0, 32'h9876_5432, 2);
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      access(r < 5 || r == 9, r >= 5, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(1, TO + 2));
    end
    // Reset during the second WAIT cycle with a late ready pulse that must be discarded.
    MemRead = 1; MemWrite = 0; Memsel = 3'b000; Addr = 32'h5000; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; MemRead = 0; mem_ready = 1;
    model_datar = '0;
    @(negedge clk);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_datar", DataR, 0);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_fault", Fault, 0);
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    chk("idle_ready_ignored", mem_req, 0);
    chk("idle_datar_kept", DataR, model_datar);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
